// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, responder states and mode-register fields.
// Used by both the responder model and the controller.
package sdram_pkg;

  // Encoding is {cs_n, ras_n, cas_n, we_n}
  typedef enum logic [3:0] {
    CMD_LOAD_MODE = 4'b0000,
    CMD_REFRESH   = 4'b0001,
    CMD_PRECHARGE = 4'b0010,
    CMD_ACTIVE    = 4'b0011,
    CMD_WRITE     = 4'b0100,
    CMD_READ      = 4'b0101,
    CMD_NOP       = 4'b0111
  } sdram_cmd_e;

  typedef enum logic [2:0] {
    ST_UNINIT,
    ST_IDLE,
    ST_ACTIVATING,
    ST_ACTIVE,
    ST_REFRESH
  } sdram_state_e;

  localparam int SDRAM_ADDR_W = 12;
  localparam int MODE_BL_LSB  = 0;
  localparam int MODE_BL_MSB  = 2;
  localparam int MODE_CL_LSB  = 4;
  localparam int MODE_CL_MSB  = 6;
  localparam int ADDR_AP_BIT  = 10;

  // Deselect and burst-terminate both behave as NOP for a burst-length-1 device
  function automatic sdram_cmd_e decode_cmd(input logic [3:0] pins);
    sdram_cmd_e cmd;
    case (pins)
      4'b0000: cmd = CMD_LOAD_MODE;
      4'b0001: cmd = CMD_REFRESH;
      4'b0010: cmd = CMD_PRECHARGE;
      4'b0011: cmd = CMD_ACTIVE;
      4'b0100: cmd = CMD_WRITE;
      4'b0101: cmd = CMD_READ;
      default: cmd = CMD_NOP;
    endcase
    return cmd;
  endfunction

  function automatic logic mode_ok(input logic [MODE_CL_MSB:0] mode);
    logic [2:0] cl;
    cl = mode[MODE_CL_MSB:MODE_CL_LSB];
    return ((cl == 3'd2) || (cl == 3'd3)) && (mode[MODE_BL_MSB:MODE_BL_LSB] == 3'd0);
  endfunction

endpackage

// File: rtl/sdram_responder_mem.sv
// Responder storage array: one RAM per byte lane, synchronous write, combinational read.
module sdram_responder_mem #(
  parameter int DATA_W = 16,
  parameter int AW     = 5
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [1:0]        lane_en_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int LANE_W = DATA_W / 2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      logic [LANE_W-1:0] lane_mem [2**AW];

      always_ff @(posedge clk_i) begin
        if (we_i && lane_en_i[gi]) begin
          lane_mem[addr_i] <= wdata_i[gi*LANE_W +: LANE_W];
        end
      end

      assign rdata_o[gi*LANE_W +: LANE_W] = lane_mem[addr_i];
    end
  endgenerate

endmodule

// File: rtl/sdram_responder.sv
// Behavioural SDRAM device responder: command FSM, protocol checking and a
// fixed-depth read pipeline whose insertion point selects the CAS latency.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ROW_BITS = 2,
  parameter int COL_BITS = 3,
  parameter int TRCD     = 2,
  parameter int TRFC     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cs_n,
  input  logic                    ras_n,
  input  logic                    cas_n,
  input  logic                    we_n,
  input  logic [SDRAM_ADDR_W-1:0] addr,
  input  logic [1:0]              dqm,
  input  logic [DATA_W-1:0]       dq_in,
  output logic [DATA_W-1:0]       dq_out,
  output logic                    dq_oe,
  output logic                    row_open,
  output logic [1:0]              mode_cl,
  output logic                    protocol_error
);

  localparam int MEM_AW = ROW_BITS + COL_BITS;
  localparam int CNT_W  = 8;
  localparam int PIPE_D = 3;
  localparam int LANE_W = DATA_W / 2;

  sdram_state_e         state_q, state_d;
  sdram_cmd_e           cmd;
  logic [ROW_BITS-1:0]  row_q, row_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           mode_cl_q, mode_cl_d;
  logic                 err_q, err_d;
  logic [PIPE_D-1:0]    pipe_vld_q, pipe_vld_d;
  logic [DATA_W-1:0]    pipe_dat_q [PIPE_D];
  logic [DATA_W-1:0]    pipe_dat_d [PIPE_D];
  logic                 dq_oe_q, dq_oe_d;
  logic [DATA_W-1:0]    dq_out_q, dq_out_d;
  logic                 mem_we;
  logic                 rd_issue;
  logic [MEM_AW-1:0]    mem_addr;
  logic [DATA_W-1:0]    rd_word;
  logic [DATA_W-1:0]    rd_masked;
  logic                 unused_addr_hi;

  // Address bits above the mode field and beside A10 carry no meaning here
  assign unused_addr_hi = ^{addr[11], addr[9:7]};

  assign cmd      = decode_cmd({cs_n, ras_n, cas_n, we_n});
  assign mem_addr = {row_q, addr[COL_BITS-1:0]};

  sdram_responder_mem #(
    .DATA_W (DATA_W),
    .AW     (MEM_AW)
  ) u_mem (
    .clk_i     (clk),
    .we_i      (mem_we),
    .lane_en_i (~dqm),
    .addr_i    (mem_addr),
    .wdata_i   (dq_in),
    .rdata_o   (rd_word)
  );

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_mask
      assign rd_masked[gi*LANE_W +: LANE_W] = dqm[gi] ? '0 : rd_word[gi*LANE_W +: LANE_W];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    mode_cl_d = mode_cl_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    rd_issue  = 1'b0;
    case (state_q)
      ST_UNINIT: begin
        case (cmd)
          CMD_NOP, CMD_PRECHARGE, CMD_REFRESH: ;
          CMD_LOAD_MODE: begin
            if (mode_ok(addr[MODE_CL_MSB:0])) begin
              mode_cl_d = addr[MODE_CL_LSB +: 2];
              state_d   = ST_IDLE;
            end else begin
              err_d = 1'b1;
            end
          end
          default: err_d = 1'b1;
        endcase
      end
      ST_IDLE: begin
        case (cmd)
          CMD_NOP, CMD_PRECHARGE: ;
          CMD_ACTIVE: begin
            row_d = addr[ROW_BITS-1:0];
            if (TRCD <= 1) begin
              state_d = ST_ACTIVE;
            end else begin
              cnt_d   = CNT_W'(TRCD - 1);
              state_d = ST_ACTIVATING;
            end
          end
          CMD_REFRESH: begin
            if (TRFC > 1) begin
              cnt_d   = CNT_W'(TRFC - 1);
              state_d = ST_REFRESH;
            end
          end
          CMD_LOAD_MODE: begin
            if (mode_ok(addr[MODE_CL_MSB:0])) begin
              mode_cl_d = addr[MODE_CL_LSB +: 2];
            end else begin
              err_d = 1'b1;
            end
          end
          default: err_d = 1'b1;
        endcase
      end
      ST_ACTIVATING: begin
        if (cmd == CMD_PRECHARGE) begin
          state_d = ST_IDLE;
        end else begin
          if (cmd != CMD_NOP) begin
            err_d = 1'b1;
          end
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_ACTIVE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_ACTIVE: begin
        case (cmd)
          CMD_NOP: ;
          CMD_READ, CMD_WRITE: begin
            rd_issue = (cmd == CMD_READ);
            mem_we   = (cmd == CMD_WRITE);
            if (addr[ADDR_AP_BIT]) begin
              state_d = ST_IDLE;
            end
          end
          CMD_PRECHARGE: state_d = ST_IDLE;
          default:       err_d = 1'b1;
        endcase
      end
      ST_REFRESH: begin
        if (cmd != CMD_NOP) begin
          err_d = 1'b1;
        end
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_UNINIT;
    endcase
  end

  // Entries enter at stage PIPE_D-CL and all leave through the output register,
  // so a later mode change never retimes reads already in flight.
  always_comb begin
    pipe_vld_d[0] = 1'b0;
    pipe_dat_d[0] = '0;
    for (int i = 1; i < PIPE_D; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_dat_d[i] = pipe_dat_q[i-1];
    end
    if (rd_issue) begin
      if (mode_cl_q == 2'd2) begin
        pipe_vld_d[1] = 1'b1;
        pipe_dat_d[1] = rd_masked;
      end else begin
        pipe_vld_d[0] = 1'b1;
        pipe_dat_d[0] = rd_masked;
      end
    end
    dq_oe_d  = pipe_vld_q[PIPE_D-1];
    dq_out_d = pipe_vld_q[PIPE_D-1] ? pipe_dat_q[PIPE_D-1] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_UNINIT;
      row_q      <= '0;
      cnt_q      <= '0;
      mode_cl_q  <= '0;
      err_q      <= 1'b0;
      pipe_vld_q <= '0;
      for (int i = 0; i < PIPE_D; i++) begin
        pipe_dat_q[i] <= '0;
      end
      dq_oe_q    <= 1'b0;
      dq_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      mode_cl_q  <= mode_cl_d;
      err_q      <= err_d;
      pipe_vld_q <= pipe_vld_d;
      for (int i = 0; i < PIPE_D; i++) begin
        pipe_dat_q[i] <= pipe_dat_d[i];
      end
      dq_oe_q    <= dq_oe_d;
      dq_out_q   <= dq_out_d;
    end
  end

  assign dq_out         = dq_out_q;
  assign dq_oe          = dq_oe_q;
  assign row_open       = (state_q == ST_ACTIVATING) || (state_q == ST_ACTIVE);
  assign mode_cl        = mode_cl_q;
  assign protocol_error = err_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: reads are scoreboarded with their expected
// arrival cycle and matched by a negedge monitor.
module tb_sdram_responder;

  localparam logic [3:0] P_NOP = 4'b0111;
  localparam logic [3:0] P_ACT = 4'b0011;
  localparam logic [3:0] P_RD  = 4'b0101;
  localparam logic [3:0] P_WR  = 4'b0100;
  localparam logic [3:0] P_PRE = 4'b0010;
  localparam logic [3:0] P_REF = 4'b0001;
  localparam logic [3:0] P_LMR = 4'b0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b0, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [11:0] addr = '0;
  logic [1:0]  dqm = '0;
  logic [15:0] dq_in = '0;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        row_open;
  logic [1:0]  mode_cl;
  logic        protocol_error;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  sdram_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cs_n           (cs_n),
    .ras_n          (ras_n),
    .cas_n          (cas_n),
    .we_n           (we_n),
    .addr           (addr),
    .dqm            (dqm),
    .dq_in          (dq_in),
    .dq_out         (dq_out),
    .dq_oe          (dq_oe),
    .row_open       (row_open),
    .mode_cl        (mode_cl),
    .protocol_error (protocol_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one command for the next rising edge
  task automatic step(input logic [3:0] p, input logic [11:0] a, input logic [1:0] m,
                      input logic [15:0] d);
    @(negedge clk);
    {cs_n, ras_n, cas_n, we_n} = p;
    addr  = a;
    dqm   = m;
    dq_in = d;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(P_NOP, 12'h000, 2'b00, 16'h0000);
  endtask

  task automatic rd(input logic [11:0] a, input logic [1:0] m, input logic [15:0] exp, input int cl);
    exp_t e;
    step(P_RD, a, m, 16'h0000);
    e.cyc  = cyc + 1 + cl;
    e.data = exp;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (dq_oe === 1'b1) begin
      if (sb.size() == 0) begin
        chk("dq_oe_unexpected", 32'(dq_oe), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("read cyc=%0d dq_out=%h expected=%h at_cyc=%0d", cyc, dq_out, e.data, e.cyc);
        chk("rd_data", 32'(dq_out), 32'(e.data));
        chk("rd_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      chk("dq_oe_missing", 32'(dq_oe), 32'd1);
      void'(sb.pop_front());
    end
  end

  initial begin
    // Reset values
    nop(2);
    chk("rst_dq_oe", 32'(dq_oe), 32'd0);
    chk("rst_dq_out", 32'(dq_out), 32'd0);
    chk("rst_row_open", 32'(row_open), 32'd0);
    chk("rst_mode_cl", 32'(mode_cl), 32'd0);
    chk("rst_err", 32'(protocol_error), 32'd0);
    rst_n = 1'b1;
    nop(1);

    // CL=2 write then read
    step(P_LMR, 12'h020, 2'b00, 16'h0000);
    step(P_ACT, 12'h001, 2'b00, 16'h0000);
    step(P_NOP, 12'h000, 2'b00, 16'h0000);
    chk("cl2_mode_cl", 32'(mode_cl), 32'd2);
    chk("activating_row_open", 32'(row_open), 32'd1);
    step(P_WR, 12'h005, 2'b00, 16'hA5C3);
    rd(12'h005, 2'b00, 16'hA5C3, 2);
    nop(4);
    chk("cl2_no_err", 32'(protocol_error), 32'd0);

    // CL=3, lane-masked write and lane-masked read
    step(P_PRE, 12'h000, 2'b00, 16'h0000);
    step(P_LMR, 12'h030, 2'b00, 16'h0000);
    step(P_ACT, 12'h002, 2'b00, 16'h0000);
    step(P_NOP, 12'h000, 2'b00, 16'h0000);
    chk("cl3_mode_cl", 32'(mode_cl), 32'd3);
    step(P_WR, 12'h005, 2'b00, 16'h1234);
    step(P_WR, 12'h005, 2'b01, 16'hFFFF);
    rd(12'h005, 2'b00, 16'hFF34, 3);
    rd(12'h005, 2'b10, 16'h0034, 3);
    nop(5);
    chk("cl3_no_err", 32'(protocol_error), 32'd0);

    // Illegal commands: READ in IDLE, ACTIVE while activating, bad LOAD MODE
    step(P_PRE, 12'h000, 2'b00, 16'h0000);
    step(P_NOP, 12'h000, 2'b00, 16'h0000);
    chk("pre_row_closed", 32'(row_open), 32'd0);
    chk("pre_err_clear", 32'(protocol_error), 32'd0);
    step(P_RD, 12'h005, 2'b00, 16'h0000);
    step(P_NOP, 12'h000, 2'b00, 16'h0000);
    chk("rd_idle_err", 32'(protocol_error), 32'd1);
    chk("rd_idle_row_closed", 32'(row_open), 32'd0);
    step(P_ACT, 12'h001, 2'b00, 16'h0000);
    step(P_ACT, 12'h003, 2'b00, 16'h0000);
    step(P_LMR, 12'h010, 2'b00, 16'h0000);
    step(P_NOP, 12'h000, 2'b00, 16'h0000);
    chk("bad_lmr_mode_kept", 32'(mode_cl), 32'd3);
    chk("bad_act_row_open", 32'(row_open), 32'd1);
    rd(12'h005, 2'b00, 16'hA5C3, 3);
    nop(5);

    // Back-to-back reads, auto-precharge on the last
    step(P_WR, 12'h000, 2'b00, 16'h1A1A);
    step(P_WR, 12'h001, 2'b00, 16'h2B2B);
    step(P_WR, 12'h002, 2'b00, 16'h3C3C);
    step(P_WR, 12'h003, 2'b00, 16'h4D4D);
    rd(12'h000, 2'b00, 16'h1A1A, 3);
    rd(12'h001, 2'b00, 16'h2B2B, 3);
    rd(12'h002, 2'b00, 16'h3C3C, 3);
    rd(12'h403, 2'b00, 16'h4D4D, 3);
    step(P_NOP, 12'h000, 2'b00, 16'h0000);
    chk("autopre_row_closed", 32'(row_open), 32'd0);
    nop(5);

    // AUTO REFRESH busy window
    step(P_REF, 12'h000, 2'b00, 16'h0000);
    step(P_NOP, 12'h000, 2'b00, 16'h0000);
    step(P_ACT, 12'h000, 2'b00, 16'h0000);
    step(P_NOP, 12'h000, 2'b00, 16'h0000);
    chk("ref_busy_act_ignored", 32'(row_open), 32'd0);
    step(P_ACT, 12'h000, 2'b00, 16'h0000);
    step(P_NOP, 12'h000, 2'b00, 16'h0000);
    chk("ref_done_act_taken", 32'(row_open), 32'd1);
    step(P_NOP, 12'h000, 2'b00, 16'h0000);
    step(P_WR, 12'h007, 2'b00, 16'h5A5A);
    rd(12'h007, 2'b00, 16'h5A5A, 3);
    nop(5);
    chk("err_sticky", 32'(protocol_error), 32'd1);

    // Reset one cycle after a CL=3 READ
    step(P_RD, 12'h007, 2'b00, 16'h0000);
    step(P_NOP, 12'h000, 2'b00, 16'h0000);
    rst_n = 1'b0;
    nop(2);
    chk("rst2_dq_oe", 32'(dq_oe), 32'd0);
    chk("rst2_dq_out", 32'(dq_out), 32'd0);
    chk("rst2_row_open", 32'(row_open), 32'd0);
    chk("rst2_mode_cl", 32'(mode_cl), 32'd0);
    chk("rst2_err", 32'(protocol_error), 32'd0);
    rst_n = 1'b1;
    nop(4);
    step(P_LMR, 12'h020, 2'b00, 16'h0000);
    step(P_ACT, 12'h001, 2'b00, 16'h0000);
    step(P_NOP, 12'h000, 2'b00, 16'h0000);
    rd(12'h005, 2'b00, 16'hA5C3, 2);
    rd(12'h003, 2'b00, 16'h4D4D, 2);
    nop(5);
    chk("reinit_no_err", 32'(protocol_error), 32'd0);
    chk("reinit_mode_cl", 32'(mode_cl), 32'd2);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_responder.md
SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 Parameter DATA_W, default 16, dq width in bits (two byte lanes).
REQ-002 Parameter ROW_BITS, default 2, implemented row address bits (4 rows).
REQ-003 Parameter COL_BITS, default 3, implemented column address bits (8 columns).
REQ-004 Parameter TRCD, default 2, ACTIVE-to-READ/WRITE minimum spacing in cycles.
REQ-005 Parameter TRFC, default 4, AUTO REFRESH busy time in cycles.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 cs_n, ras_n, cas_n, we_n  input  1 each  SDRAM command pins, active-low, sampled at rising edge.
REQ-009 addr  input  12  row address on ACTIVE; column on READ/WRITE (A10 = auto-precharge); mode value on LOAD MODE.
REQ-010 dqm  input  2  byte mask, bit i masks lane i, sampled with READ/WRITE.
REQ-011 dq_in  input  DATA_W  write data, sampled in the WRITE command cycle.
REQ-012 dq_out  output  DATA_W  read data; dq_oe  output  1  drive enable for dq_out.
REQ-013 row_open  output  1  high while a row is active; mode_cl  output  2  loaded CAS latency (0 = mode not loaded).
REQ-014 protocol_error  output  1  sticky flag, set on any illegal command.

Function
REQ-015 Command decode {cs_n,ras_n,cas_n,we_n}: 1xxx/0111/0110 NOP; 0011 ACTIVE; 0101 READ; 0100 WRITE; 0010 PRECHARGE; 0001 AUTO REFRESH; 0000 LOAD MODE.
REQ-016 States: UNINIT, IDLE, ACTIVATING, ACTIVE, REFRESH; reset enters UNINIT.
REQ-017 UNINIT: LOAD MODE with addr[6:4] in {2,3} and addr[2:0]=000 sets mode_cl and enters IDLE; illegal mode value sets protocol_error, stays UNINIT; PRECHARGE/REFRESH accepted without effect; other commands are errors.
REQ-018 IDLE: ACTIVE latches addr[ROW_BITS-1:0], loads tRCD counter with TRCD-1, enters ACTIVATING (or ACTIVE directly if TRCD=1); AUTO REFRESH enters REFRESH for TRFC cycles; LOAD MODE reloads mode under REQ-017 rules; PRECHARGE is a legal no-op; READ/WRITE are errors.
REQ-019 ACTIVATING: counter decrements each cycle, ACTIVE on zero; any non-NOP except PRECHARGE is an error; PRECHARGE returns to IDLE.
REQ-020 ACTIVE: READ/WRITE legal every cycle; PRECHARGE enters IDLE next cycle; ACTIVE, REFRESH, LOAD MODE are errors.
REQ-021 REFRESH: any non-NOP is an error; returns to IDLE after TRFC cycles.
REQ-022 row_open is high exactly in ACTIVATING and ACTIVE.
REQ-023 WRITE: store dq_in at (open row, addr[COL_BITS-1:0]) with per-lane masking by dqm; visible to a READ issued the next cycle.
REQ-024 READ: read data appears on dq_out with dq_oe high for exactly one cycle, mode_cl cycles after the READ edge; dqm-masked lanes drive 0.
REQ-025 Read pipeline depth 3; back-to-back READs produce back-to-back dq_oe cycles in order; burst length fixed at 1.
REQ-026 addr[10]=1 on READ/WRITE: access completes, then state enters IDLE next cycle (auto-precharge); in-flight read data still delivered.
REQ-027 PRECHARGE or LOAD MODE never cancels in-flight read data.
REQ-028 Erroneous commands have no effect on state or memory beyond setting protocol_error; protocol_error clears only by reset.
REQ-029 Unimplemented high address bits are ignored without error.

Reset
REQ-030 rst_n low asynchronously: state UNINIT, mode_cl=0, row_open=0, dq_oe=0, dq_out=0, protocol_error=0, read pipeline and counters cleared.
REQ-031 Reset mid-read discards pending data; memory contents are not reset.

Structure
REQ-032 Shared package sdram_pkg holds the command enum, 4-bit encodings, state enum, and mode-field bit positions, shared with sdram_controller.
REQ-033 Storage in sub-module sdram_responder_mem (2^(ROW_BITS+COL_BITS) x DATA_W, byte-lane write enables, synchronous write, combinational read).

Verification
REQ-034 LOAD MODE addr=0x020, ACTIVE row 1, NOP, WRITE col 5 data 0xA5C3 dqm=00, READ col 5 -> dq_oe high 2 cycles after READ, dq_out=0xA5C3, no error.
REQ-035 CL=3, WRITE 0x1234 then WRITE 0xFFFF dqm=01 same address, READ -> dq_out=0xFF34 3 cycles after READ.
REQ-036 READ in IDLE, ACTIVE at ACTIVATING+0, LOAD MODE addr=0x010 -> protocol_error set, state/memory unchanged.
REQ-037 Four consecutive READs cols 0-3 with A10=1 on the last -> four consecutive dq_oe cycles, row_open low the cycle after the last READ.
REQ-038 AUTO REFRESH then ACTIVE 2 cycles later -> error; ACTIVE after TRFC -> accepted.
REQ-039 rst_n low 1 cycle after READ (CL=3) -> dq_oe never asserts, outputs at reset values, earlier-written data still readable after re-init.
